// File: rtl/resp_return.sv
// resp_return: return path between the address decoder and NS slaves.
// Grants one slave at a time, counts outstanding requests, muxes the
// granted slave's ack/err/data back to the master, and synthesises a bus
// error for requests decoded to the "no slave" slot (bit NS).
// Optional response watchdog: define RESP_TIMEOUT_EN.
module resp_return #(
    parameter int NS           = 8,
    parameter int DW           = 32,
    parameter int LGMAXOUT     = 5,
    parameter int TIMEOUT      = 1024,
    parameter int OPT_LOWPOWER = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cyc,
    input  logic             i_req,
    input  logic [NS:0]      i_decode,
    output logic             o_stall,
    input  logic [NS-1:0]    i_sack,
    input  logic [NS-1:0]    i_serr,
    input  logic [NS*DW-1:0] i_sdata,
    output logic             o_ack,
    output logic             o_err,
    output logic [DW-1:0]    o_data,
    output logic [NS:0]      o_sel,
    output logic             o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_NOSLAVE} state_t;

    localparam logic [LGMAXOUT-1:0] MAXOUT = '1;
    localparam logic [LGMAXOUT-1:0] ONE    = LGMAXOUT'(1);

    state_t              r_state;
    logic [LGMAXOUT-1:0] r_count;

    logic                w_nonzero;
    logic                w_noslave;
    logic                w_accept;
    logic                w_slv_ack;
    logic                w_slv_err;
    logic                w_resp;
    logic                w_err_slv;
    logic                w_timeout;
    logic                w_fault;
    logic                w_err_nxt;
    logic                w_ack_nxt;
    logic [LGMAXOUT-1:0] w_count_nxt;
    logic [DW-1:0]       w_mux;

    assign w_nonzero = (r_count != '0);
    assign w_noslave = (r_state == S_NOSLAVE);
    assign o_busy    = w_nonzero;

    // A request waits while the bus is down, another slave owns the
    // outstanding work, the counter is full, or a synthesised error is due.
    assign o_stall  = !i_cyc || (w_nonzero && (i_decode != o_sel))
                    || (r_count == MAXOUT) || w_noslave;
    assign w_accept = i_cyc && i_req && !o_stall;

    // Only the granted slave may answer, and only while work is outstanding.
    assign w_slv_ack = |(i_sack & o_sel[NS-1:0]);
    assign w_slv_err = |(i_serr & o_sel[NS-1:0]);
    assign w_resp    = i_cyc && w_nonzero && (w_slv_ack || w_slv_err);
    assign w_err_slv = i_cyc && w_nonzero && w_slv_err;
    assign w_fault   = w_err_slv || w_timeout;
    assign w_err_nxt = w_fault || (w_accept && i_decode[NS]);
    assign w_ack_nxt = i_cyc && w_nonzero && w_slv_ack && !w_err_nxt;

    // Outstanding count after this cycle's accept/response pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_accept, w_resp})
            2'b10:   w_count_nxt = r_count + ONE;
            2'b01:   w_count_nxt = r_count - ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Read-data mux on the one-hot grant; the no-slave slot returns zero.
    always_comb begin
        w_mux = '0;
        for (int k = 0; k < NS; k++) begin
            if (o_sel[k]) begin
                w_mux = w_mux | i_sdata[k*DW +: DW];
            end
        end
    end

`ifdef RESP_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] r_wdog;

    assign w_timeout = i_cyc && w_nonzero && !w_resp && !w_accept
                     && (r_wdog == WDW'(TIMEOUT - 1));

    // Watchdog: counts silent busy cycles, restarts on any progress.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wdog <= '0;
        end else if (!i_cyc || !w_nonzero || w_resp || w_accept || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WDW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Grant/count state machine with registered master-side responses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            o_sel   <= '0;
            o_ack   <= 1'b0;
            o_err   <= 1'b0;
            o_data  <= '0;
        end else begin
            o_ack <= w_ack_nxt;
            o_err <= w_err_nxt;
            if ((OPT_LOWPOWER != 0) && !w_ack_nxt) begin
                o_data <= '0;
            end else begin
                o_data <= w_mux;
            end

            if (!i_cyc || w_fault || w_noslave) begin
                // Abort, error, or the synthesised error just issued:
                // everything still outstanding is abandoned.
                r_state <= S_IDLE;
                r_count <= '0;
                o_sel   <= '0;
            end else if (w_accept && i_decode[NS]) begin
                r_state <= S_NOSLAVE;
                r_count <= ONE;
                o_sel   <= i_decode;
            end else begin
                r_count <= w_count_nxt;
                if (w_accept) begin
                    o_sel <= i_decode;
                end else if (w_count_nxt == '0) begin
                    o_sel <= '0;
                end
                r_state <= (w_count_nxt != '0) ? S_OPEN : S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_resp_return.sv
module tb_resp_return;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int TMO = 16;
    localparam logic [NS:0] SEL1  = 9'h002;
    localparam logic [NS:0] SEL2  = 9'h004;
    localparam logic [NS:0] SEL5  = 9'h020;
    localparam logic [NS:0] SELNS = 9'h100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cyc = 1'b0;
    logic             req = 1'b0;
    logic [NS:0]      decode = '0;
    logic [NS-1:0]    sack = '0;
    logic [NS-1:0]    serr = '0;
    logic [NS*DW-1:0] sdata = '0;

    logic          a_stall, a_ack, a_err, a_busy;
    logic [DW-1:0] a_data;
    logic [NS:0]   a_sel;
    logic          b_stall, b_ack, b_err, b_busy;
    logic [DW-1:0] b_data;
    logic [NS:0]   b_sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    resp_return #(.NS(NS), .DW(DW), .LGMAXOUT(5), .TIMEOUT(TMO), .OPT_LOWPOWER(0)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc), .i_req(req), .i_decode(decode),
        .o_stall(a_stall), .i_sack(sack), .i_serr(serr), .i_sdata(sdata),
        .o_ack(a_ack), .o_err(a_err), .o_data(a_data), .o_sel(a_sel), .o_busy(a_busy));

    resp_return #(.NS(NS), .DW(DW), .LGMAXOUT(2), .TIMEOUT(TMO), .OPT_LOWPOWER(0)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_cyc(cyc), .i_req(req), .i_decode(decode),
        .o_stall(b_stall), .i_sack(sack), .i_serr(serr), .i_sdata(sdata),
        .o_ack(b_ack), .o_err(b_err), .o_data(b_data), .o_sel(b_sel), .o_busy(b_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < NS; k++) sdata[k*DW +: DW] = $urandom;
    endtask

    task automatic reset_bus();
        cyc = 1'b0; req = 1'b0; sack = '0; serr = '0; decode = '0;
        tick();
        cyc = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc = 1'b0; req = 1'b1; sack = '1; decode = SEL2;
        rand_data();
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (a_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack got %b want 0", a_ack); end
        n_checks++; if (a_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", a_err); end
        n_checks++; if (a_data !== '0) begin n_errors++; $display("FAIL reset_data got %h want 0", a_data); end
        n_checks++; if (a_sel !== '0) begin n_errors++; $display("FAIL reset_sel got %h want 0", a_sel); end
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
        n_checks++; if (a_stall !== 1'b1) begin n_errors++; $display("FAIL reset_stall got %b want 1", a_stall); end
        rst_n = 1'b1; cyc = 1'b1; req = 1'b0; sack = '0;
        #1;
        n_checks++; if (a_stall !== 1'b0) begin n_errors++; $display("FAIL release_stall got %b want 0", a_stall); end
        tick();
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL release_busy got %b want 0", a_busy); end
    endtask

    task automatic test_burst();
        int acc, ackd;
        reset_bus();
        for (int cy = 0; cy < 9; cy++) begin
            rand_data();
            req = (cy < 4); decode = SEL2;
            sack = '0;
            if (cy >= 3 && cy <= 6) begin
                sack[2] = 1'b1;
                sdata[2*DW +: DW] = 32'hA0 + 32'(cy - 3);
            end
            #1;
            if (cy < 4) begin
                n_checks++; if (a_stall !== 1'b0) begin n_errors++; $display("FAIL burst_stall cy%0d got %b want 0", cy, a_stall); end
            end
            tick();
            n_checks++;
            if (a_ack !== (cy >= 3 && cy <= 6)) begin n_errors++; $display("FAIL burst_ack cy%0d got %b want %b", cy + 1, a_ack, (cy >= 3 && cy <= 6)); end
            if (cy >= 3 && cy <= 6) begin
                n_checks++; if (a_data !== 32'hA0 + 32'(cy - 3)) begin n_errors++; $display("FAIL burst_data cy%0d got %h want %h", cy + 1, a_data, 32'hA0 + 32'(cy - 3)); end
            end
            acc  = (cy + 1 < 4) ? cy + 1 : 4;
            ackd = (cy >= 3) ? ((cy - 2 < 4) ? cy - 2 : 4) : 0;
            n_checks++; if (a_busy !== (acc - ackd > 0)) begin n_errors++; $display("FAIL burst_busy cy%0d got %b want %b", cy + 1, a_busy, (acc - ackd > 0)); end
        end
        req = 1'b0; sack = '0;
        reset_bus();
    endtask

    task automatic test_switch();
        reset_bus();
        for (int cy = 0; cy < 7; cy++) begin
            req = 1'b1;
            decode = (cy < 2) ? SEL1 : SEL5;
            sack = '0;
            sack[1] = (cy == 3 || cy == 5);
            #1;
            n_checks++; if (a_stall !== (cy >= 2 && cy <= 5)) begin n_errors++; $display("FAIL switch_stall cy%0d got %b want %b", cy, a_stall, (cy >= 2 && cy <= 5)); end
            tick();
            if (cy == 3) begin
                n_checks++; if (a_sel !== SEL1) begin n_errors++; $display("FAIL switch_hold got %h want %h", a_sel, SEL1); end
            end
        end
        n_checks++; if (a_sel !== SEL5) begin n_errors++; $display("FAIL switch_sel got %h want %h", a_sel, SEL5); end
        n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL switch_busy got %b want 1", a_busy); end
        req = 1'b0; sack = '0;
        reset_bus();
    endtask

    task automatic test_noslave();
        reset_bus();
        req = 1'b1; decode = SELNS;
        #1;
        n_checks++; if (a_stall !== 1'b0) begin n_errors++; $display("FAIL ns_stall got %b want 0", a_stall); end
        tick();
        n_checks++; if (a_err !== 1'b1) begin n_errors++; $display("FAIL ns_err got %b want 1", a_err); end
        n_checks++; if (a_ack !== 1'b0) begin n_errors++; $display("FAIL ns_ack got %b want 0", a_ack); end
        decode = 9'h001;
        #1;
        n_checks++; if (a_stall !== 1'b1) begin n_errors++; $display("FAIL ns_block got %b want 1", a_stall); end
        tick();
        n_checks++; if (a_err !== 1'b0) begin n_errors++; $display("FAIL ns_err_once got %b want 0", a_err); end
        n_checks++; if (a_sel !== '0) begin n_errors++; $display("FAIL ns_sel got %h want 0", a_sel); end
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL ns_busy got %b want 0", a_busy); end
        req = 1'b0;
        reset_bus();
    endtask

    task automatic test_full_abort();
        reset_bus();
        req = 1'b1; decode = 9'h010;
        for (int cy = 0; cy < 3; cy++) begin
            #1;
            n_checks++; if (b_stall !== 1'b0) begin n_errors++; $display("FAIL full_accept%0d got %b want 0", cy, b_stall); end
            tick();
        end
        #1;
        n_checks++; if (b_stall !== 1'b1) begin n_errors++; $display("FAIL full_stall got %b want 1", b_stall); end
        n_checks++; if (a_stall !== 1'b0) begin n_errors++; $display("FAIL notfull_stall got %b want 0", a_stall); end
        tick();
        cyc = 1'b0; req = 1'b0;
        tick();
        n_checks++; if (b_busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b want 0", b_busy); end
        n_checks++; if (b_sel !== '0) begin n_errors++; $display("FAIL abort_sel got %h want 0", b_sel); end
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy_a got %b want 0", a_busy); end
        cyc = 1'b1; sack = '0; sack[4] = 1'b1;
        tick();
        n_checks++; if (b_ack !== 1'b0) begin n_errors++; $display("FAIL late_ack got %b want 0", b_ack); end
        n_checks++; if (a_ack !== 1'b0) begin n_errors++; $display("FAIL late_ack_a got %b want 0", a_ack); end
        sack = '0;
        reset_bus();
    endtask

    task automatic test_timeout();
        reset_bus();
        req = 1'b1; decode = 9'h040;
        tick();
        req = 1'b0;
`ifdef RESP_TIMEOUT_EN
        for (int cy = 1; cy <= 17; cy++) begin
            tick();
            n_checks++; if (a_err !== (cy == 16)) begin n_errors++; $display("FAIL tmo_err cy%0d got %b want %b", cy + 1, a_err, (cy == 16)); end
        end
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL tmo_busy got %b want 0", a_busy); end
`else
        for (int cy = 0; cy < 40; cy++) tick();
        n_checks++; if (a_busy !== 1'b1) begin n_errors++; $display("FAIL hang_busy got %b want 1", a_busy); end
        n_checks++; if (a_err !== 1'b0) begin n_errors++; $display("FAIL hang_err got %b want 0", a_err); end
`endif
        reset_bus();
    endtask

    // Reference: transaction-level bookkeeping of owner slave and
    // outstanding count; slave index -1 means nothing granted.
    task automatic test_random();
        int m_count, m_sel, m_sil, dec;
        bit exp_stall, acc, sa, se, e_ack, e_err, tmo, e_busy;
        logic [DW-1:0] e_data;
        logic [NS:0] e_sel;
        m_count = 0; m_sel = -1; m_sil = 0;
        reset_bus();
        for (int n = 0; n < 600; n++) begin
            cyc = ($urandom % 24) != 0;
            req = $urandom % 2;
            case ($urandom % 8)
                0, 1:    dec = 0;
                2, 3, 4: dec = 1;
                5, 6:    dec = 3;
                default: dec = NS;
            endcase
            decode = '0; decode[dec] = 1'b1;
            sack = 8'($urandom) & 8'h0B;
            serr = (($urandom % 12) == 0) ? (8'($urandom) & 8'h0B) : 8'h00;
            rand_data();
            #1;
            exp_stall = !cyc || (m_count > 0 && dec != m_sel) || m_count == 31 || m_sel == NS;
            n_checks++; if (a_stall !== exp_stall) begin n_errors++; $display("FAIL rnd_stall n%0d got %b want %b", n, a_stall, exp_stall); end
            acc = cyc && req && !exp_stall;
            sa = cyc && m_count > 0 && m_sel >= 0 && m_sel < NS && sack[m_sel];
            se = cyc && m_count > 0 && m_sel >= 0 && m_sel < NS && serr[m_sel];
            tmo = 1'b0;
`ifdef RESP_TIMEOUT_EN
            if (cyc && m_count > 0 && !(sa || se) && !acc) begin
                m_sil++;
                if (m_sil == TMO) begin tmo = 1'b1; m_sil = 0; end
            end else begin
                m_sil = 0;
            end
`endif
            e_err  = se || tmo || (acc && dec == NS);
            e_ack  = sa && !e_err;
            e_data = (m_sel >= 0 && m_sel < NS) ? sdata[m_sel*DW +: DW] : '0;
            if (!cyc || se || tmo || m_sel == NS) begin
                m_count = 0; m_sel = -1;
            end else if (acc && dec == NS) begin
                m_count = 1; m_sel = NS;
            end else begin
                m_count = m_count + (acc ? 1 : 0) - (sa ? 1 : 0);
                if (acc) m_sel = dec;
                else if (m_count == 0) m_sel = -1;
            end
            e_sel = '0;
            if (m_sel >= 0) e_sel[m_sel] = 1'b1;
            e_busy = m_count > 0;
            tick();
            n_checks++; if (a_ack !== e_ack) begin n_errors++; $display("FAIL rnd_ack n%0d got %b want %b", n, a_ack, e_ack); end
            n_checks++; if (a_err !== e_err) begin n_errors++; $display("FAIL rnd_err n%0d got %b want %b", n, a_err, e_err); end
            n_checks++; if (a_data !== e_data) begin n_errors++; $display("FAIL rnd_data n%0d got %h want %h", n, a_data, e_data); end
            n_checks++; if (a_sel !== e_sel) begin n_errors++; $display("FAIL rnd_sel n%0d got %h want %h", n, a_sel, e_sel); end
            n_checks++; if (a_busy !== e_busy) begin n_errors++; $display("FAIL rnd_busy n%0d got %b want %b", n, a_busy, e_busy); end
        end
        reset_bus();
    endtask

    initial begin
        test_reset();
        test_burst();
        test_switch();
        test_noslave();
        test_full_abort();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "time limit");
    end

endmodule
